// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported block RAM between the CPU and an
// auxiliary master; one transaction in flight, read data returned two cycles after sampling.
module mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              aux_req,
   input  logic              aux_we,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [DATA_W-1:0] aux_wdata,
   output logic              aux_gnt,
   output logic              aux_rvalid,
   output logic [DATA_W-1:0] aux_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state, state_nxt;
   logic              owner, owner_nxt;   // 0 = CPU, 1 = AUX
   logic              last, last_nxt;
   logic              lat_we, lat_we_nxt;
   logic [ADDR_W-1:0] lat_addr, lat_addr_nxt;
   logic [DATA_W-1:0] lat_wdata, lat_wdata_nxt;
   logic              winner;

   // On a tie the master that did not win last time goes first.
   assign winner = (cpu_req && aux_req) ? ~last : aux_req;

   always_comb begin
      state_nxt     = state;
      owner_nxt     = owner;
      last_nxt      = last;
      lat_we_nxt    = lat_we;
      lat_addr_nxt  = lat_addr;
      lat_wdata_nxt = lat_wdata;
      case (state)
         IDLE: begin
            if (cpu_req || aux_req) begin
               state_nxt     = ACCESS;
               owner_nxt     = winner;
               last_nxt      = winner;
               lat_we_nxt    = winner ? aux_we    : cpu_we;
               lat_addr_nxt  = winner ? aux_addr  : cpu_addr;
               lat_wdata_nxt = winner ? aux_wdata : cpu_wdata;
            end
         end
         ACCESS:  state_nxt = lat_we ? IDLE : RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= 1'b0;
         last      <= 1'b1;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         last      <= last_nxt;
         lat_we    <= lat_we_nxt;
         lat_addr  <= lat_addr_nxt;
         lat_wdata <= lat_wdata_nxt;
      end
   end

   // Everything handed back to the masters is suppressed while rst is high so an
   // aborted transaction leaves no trace, including a write sitting in ACCESS.
   assign mem_addr   = lat_addr;
   assign mem_wdata  = lat_wdata;
   assign mem_we     = (state == ACCESS) && lat_we && !rst;
   assign cpu_gnt    = (state == ACCESS) && !owner && !rst;
   assign aux_gnt    = (state == ACCESS) &&  owner && !rst;
   assign cpu_rvalid = (state == RESP)   && !owner && !rst;
   assign aux_rvalid = (state == RESP)   &&  owner && !rst;
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
   assign aux_rdata  = aux_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle synchronous-read RAM model behind it.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, aux_req, aux_we;
   logic [15:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
   logic        cpu_gnt, cpu_rvalid, aux_gnt, aux_rvalid;
   logic [15:0] cpu_rdata, aux_rdata;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;

   logic        mem_init;
   logic [15:0] mem [0:255];

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
      .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   // Block RAM: synchronous write, registered read of the current address.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
         mem[8'h10] <= 16'hBEEF;
      end else if (mem_we) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
      mem_rdata <= mem[mem_addr[7:0]];
   end

   task automatic test_reset;
      rst = 1'b1; mem_init = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 16'h0000;
      aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0010; aux_wdata = 16'h0000;
      @(posedge clk); #1 mem_init = 1'b0;
      @(negedge clk);
      vectors++;
      if ({cpu_gnt, aux_gnt, cpu_rvalid, aux_rvalid, cpu_rdata, aux_rdata,
           mem_addr, mem_wdata, mem_we} !== 70'd0) begin
         errors++; $display("FAIL reset_during: outputs not all zero (mem_addr=%h mem_we=%b gnt=%b%b)",
                            mem_addr, mem_we, cpu_gnt, aux_gnt);
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({cpu_gnt, aux_gnt, cpu_rvalid, aux_rvalid, cpu_rdata, aux_rdata,
           mem_addr, mem_wdata, mem_we} !== 70'd0) begin
         errors++; $display("FAIL reset_after: outputs not all zero (mem_addr=%h mem_we=%b gnt=%b%b)",
                            mem_addr, mem_we, cpu_gnt, aux_gnt);
      end
      @(posedge clk); #1 cpu_req = 1'b0; aux_req = 1'b0;
      @(negedge clk);
      vectors++;
      if ({cpu_gnt, aux_gnt} !== 2'b10) begin
         errors++; $display("FAIL reset_first_tie: gnt cpu/aux=%b%b, want 10", cpu_gnt, aux_gnt);
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_single_read;
      @(posedge clk); #1 cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
      @(negedge clk);
      vectors++;
      if (cpu_gnt !== 1'b0) begin
         errors++; $display("FAIL read_no_early_gnt: cpu_gnt=%b, want 0", cpu_gnt);
      end
      @(posedge clk); #1 cpu_req = 1'b0;
      @(negedge clk);
      vectors++;
      if ({cpu_gnt, aux_gnt, mem_we, mem_addr} !== {3'b100, 16'h0010}) begin
         errors++; $display("FAIL read_gnt: gnt=%b%b we=%b addr=%h, want 10 0 0010",
                            cpu_gnt, aux_gnt, mem_we, mem_addr);
      end
      @(posedge clk); @(negedge clk);
      vectors++;
      if ({cpu_rvalid, aux_rvalid, cpu_gnt, cpu_rdata, aux_rdata} !== {3'b100, 16'hBEEF, 16'h0000}) begin
         errors++; $display("FAIL read_rvalid: rvalid=%b%b gnt=%b rdata=%h aux_rdata=%h, want 10 0 beef 0000",
                            cpu_rvalid, aux_rvalid, cpu_gnt, cpu_rdata, aux_rdata);
      end
      @(posedge clk); @(negedge clk);
      vectors++;
      if ({cpu_rvalid, cpu_rdata} !== 17'd0) begin
         errors++; $display("FAIL read_rvalid_pulse: rvalid=%b rdata=%h, want 0 0000", cpu_rvalid, cpu_rdata);
      end
   endtask

   task automatic test_write_then_read;
      @(posedge clk); #1 aux_req = 1'b1; aux_we = 1'b1; aux_addr = 16'h0020; aux_wdata = 16'h1234;
      @(posedge clk); #1 aux_req = 1'b0; aux_we = 1'b0;
      @(negedge clk);
      vectors++;
      if ({aux_gnt, cpu_gnt, mem_we, mem_addr, mem_wdata} !== {3'b101, 16'h0020, 16'h1234}) begin
         errors++; $display("FAIL write_access: gnt aux/cpu=%b%b we=%b addr=%h wdata=%h, want 10 1 0020 1234",
                            aux_gnt, cpu_gnt, mem_we, mem_addr, mem_wdata);
      end
      // Back in IDLE straight after a write; request the read-back here.
      @(posedge clk); #1 cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
      @(negedge clk);
      vectors++;
      if ({mem_we, aux_gnt, aux_rvalid} !== 3'b000) begin
         errors++; $display("FAIL write_one_cycle: we=%b aux_gnt=%b aux_rvalid=%b, want 000",
                            mem_we, aux_gnt, aux_rvalid);
      end
      @(posedge clk); #1 cpu_req = 1'b0;
      @(negedge clk);
      vectors++;
      if ({cpu_gnt, mem_we, mem_addr} !== {2'b10, 16'h0020}) begin
         errors++; $display("FAIL readback_gnt: gnt=%b we=%b addr=%h, want 1 0 0020", cpu_gnt, mem_we, mem_addr);
      end
      @(posedge clk); @(negedge clk);
      vectors++;
      if ({cpu_rvalid, cpu_rdata} !== {1'b1, 16'h1234}) begin
         errors++; $display("FAIL readback_data: rvalid=%b rdata=%h, want 1 1234", cpu_rvalid, cpu_rdata);
      end
      @(posedge clk);
   endtask

   task automatic test_round_robin;
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
      aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0020;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); @(negedge clk);
         vectors++;
         if ({cpu_gnt, aux_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL rr_gnt[%0d]: gnt cpu/aux=%b%b, want %s", i, cpu_gnt, aux_gnt,
                               (i % 2 == 0) ? "10" : "01");
         end
         @(posedge clk); @(negedge clk);
         vectors++;
         if (i % 2 == 0) begin
            if ({cpu_rvalid, aux_rvalid, cpu_rdata, aux_rdata} !== {2'b10, 16'hBEEF, 16'h0000}) begin
               errors++; $display("FAIL rr_resp[%0d]: rvalid=%b%b rdata=%h/%h, want 10 beef/0000",
                                  i, cpu_rvalid, aux_rvalid, cpu_rdata, aux_rdata);
            end
         end else begin
            if ({cpu_rvalid, aux_rvalid, cpu_rdata, aux_rdata} !== {2'b01, 16'h0000, 16'h1234}) begin
               errors++; $display("FAIL rr_resp[%0d]: rvalid=%b%b rdata=%h/%h, want 01 0000/1234",
                                  i, cpu_rvalid, aux_rvalid, cpu_rdata, aux_rdata);
            end
         end
         if (i == 3) begin
            cpu_req = 1'b0; aux_req = 1'b0;
         end
         @(posedge clk);
      end
   endtask

   task automatic test_reset_mid_write;
      @(posedge clk); #1 cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'hDEAD;
      @(posedge clk); #1 cpu_req = 1'b0; rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (mem_we !== 1'b0) begin
         errors++; $display("FAIL midwr_we: mem_we=%b during reset, want 0", mem_we);
      end
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         vectors++;
         if ({cpu_gnt, cpu_rvalid, mem_we} !== 3'b000) begin
            errors++; $display("FAIL midwr_quiet[%0d]: gnt=%b rvalid=%b we=%b, want 000",
                               i, cpu_gnt, cpu_rvalid, mem_we);
         end
         @(posedge clk);
      end
      #1 cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030; cpu_wdata = 16'h0000;
      @(posedge clk); #1 cpu_req = 1'b0;
      @(posedge clk); @(negedge clk);
      vectors++;
      if ({cpu_rvalid, cpu_rdata} !== {1'b1, 16'h0000}) begin
         errors++; $display("FAIL midwr_readback: rvalid=%b rdata=%h, want 1 0000", cpu_rvalid, cpu_rdata);
      end
      @(posedge clk);
   endtask

   task automatic test_idle_stability;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vectors++;
         if ({mem_we, cpu_gnt, aux_gnt, cpu_rvalid, aux_rvalid, mem_addr, mem_wdata} !==
             {5'b00000, 16'h0030, 16'h0000}) begin
            errors++; $display("FAIL idle[%0d]: we=%b gnt=%b%b rvalid=%b%b addr=%h wdata=%h, want 0 00 00 0030 0000",
                               i, mem_we, cpu_gnt, aux_gnt, cpu_rvalid, aux_rvalid, mem_addr, mem_wdata);
         end
         @(posedge clk);
      end
   endtask

   initial begin
      test_reset;
      test_single_read;
      test_write_then_read;
      test_round_robin;
      test_reset_mid_write;
      test_idle_stability;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-ported data/instruction memory between the CPU core (fetch, load, store) and an auxiliary master (display scan-out / DMA). It accepts request/grant transactions from both masters, chooses a winner round-robin, drives the memory port, and returns read data to the owner with a fixed latency. It sits between the CPU's memory interface and the block RAM, which has a 1-cycle synchronous read.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU transaction request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  one-cycle grant pulse
- cpu_rvalid  out  1  one-cycle read-data-valid pulse
- cpu_rdata  out  DATA_W  read data, valid with cpu_rvalid
- aux_req, aux_we, aux_addr, aux_wdata  in  same widths as CPU equivalents
- aux_gnt, aux_rvalid, aux_rdata  out  same widths as CPU equivalents
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after address

## Operation
- States: IDLE, ACCESS, RESP. Registers: state, owner (0 = CPU, 1 = AUX), last (last winner), latched we/addr/wdata.
- IDLE: sample the cpu_req/aux_req pair. If neither is set, stay. If exactly one is set, that master wins. If both are set, the master other than `last` wins. At the edge: latch the winner's we/addr/wdata, set owner = last = winner, and go to ACCESS.
- ACCESS:
  - mem_addr, mem_wdata and mem_we come from the latched fields; mem_we = latched we & ~rst.
  - The owner's gnt is high for this cycle only.
  - Write: next state is IDLE.
  - Read: next state is RESP.
- RESP:
  - owner's rvalid = 1 for this cycle only.
  - owner's rdata = mem_rdata.
  - mem_addr holds the latched address.
  - mem_we = 0.
  - Next state is IDLE.
- Outside ACCESS, mem_we = 0. mem_addr/mem_wdata hold their latched values, with no toggling when idle.
- The non-owner's gnt and rvalid are 0 at all times. Each rdata output is valid only while its rvalid is high; it is 0 otherwise.
- Requester rules:
  - Hold req, we, addr and wdata stable from assertion until its gnt is seen.
  - The fields may change in the gnt cycle.
  - req sampled high in any later IDLE cycle is a new transaction. A master that keeps req high gets back-to-back transactions, alternating with the other master when both request.
- req is ignored in ACCESS and RESP; there is no queueing beyond the single sample in IDLE.
- Fairness: a requester waits at most one transaction of the other master before it is granted.

## Timing
- Read, request sampled in IDLE at cycle N:
  - gnt and memory address in N+1.
  - rvalid and rdata in N+2.
  - Arbiter back in IDLE at N+3.
  - 3-cycle occupancy.
- Write: gnt and mem_we in N+1, IDLE at N+2; 2-cycle occupancy.
- Maximum throughput, alternating masters: one read per 3 cycles or one write per 2 cycles.
- Reset (rst high at an edge):
  - state = IDLE and last = AUX, so the CPU wins the first tie.
  - owner = CPU.
  - Latched fields are cleared to 0.
  - All gnt, rvalid, rdata and mem_* outputs are 0 in the following cycle.
- Reset mid-transaction:
  - The transaction is aborted with no gnt or rvalid after reset.
  - mem_we is forced 0 in any cycle where rst = 1, so a write in ACCESS during reset is not performed.
  - The aborted master must re-request.
- A request present in the first IDLE cycle after reset is arbitrated in that cycle.

## Test plan
- Reset: assert rst 2 cycles with both req high, then release -> all outputs 0 during and right after reset; the CPU is granted first in the first IDLE cycle after release.
- Single CPU read: memory preloaded 0x0010 = 0xBEEF; cpu_req with addr 0x0010, we = 0 at cycle N -> cpu_gnt at N+1 with mem_addr = 0x0010; cpu_rvalid with cpu_rdata = 0xBEEF at N+2; aux_gnt and aux_rvalid stay 0.
- Write then read: aux writes 0x1234 to 0x0020 (aux_gnt with mem_we = 1, 2 cycles total); the CPU then reads 0x0020 -> cpu_rdata = 0x1234, with mem_we = 1 for exactly one cycle.
- Contention and round-robin: both req held high for 4 transactions after reset -> grant order CPU, AUX, CPU, AUX. Each master gets rvalid only for its own reads; reads take 3-cycle slots.
- Reset mid-write: rst asserted in the ACCESS cycle of a CPU write to 0x0030 (old value 0x0000) -> mem_we stays 0; a later read of 0x0030 returns 0x0000; no cpu_rvalid pulse follows.
- Idle stability: no requests for 10 cycles after a transaction -> mem_we = 0 and mem_addr constant; no gnt or rvalid pulses.
